mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multiply/divide unit for the 5-stage MIPS pipeline, placed in the E stage.
- Takes the decoder's Start, MDUOp, HIWrite and LOWrite strobes plus the two E-stage operands.
- Runs a fixed-latency busy sequence, owns the architectural HI/LO registers, and generates the D-stage stall for any later MD-class instruction (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10: busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  E-stage mult/multu/div/divu is valid this cycle.
- MDUOp  input  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- A  input  32  E-stage rs operand (forwarded value).
- B  input  32  E-stage rt operand (forwarded value).
- HIWrite  input  1  E-stage mthi; HI <= A.
- LOWrite  input  1  E-stage mtlo; LO <= A.
- MD  input  1  D-stage instruction is MD-class.
- Busy  output  1  operation in progress.
- Stall  output  1  freeze PC/IF/ID and bubble into E.
- HI  output  32  HI register, registered.
- LO  output  32  LO register, registered.

Behaviour:
- Reset, applied on any clock edge including mid-operation:
  - Busy=0, HI=0, LO=0, counter=0, state IDLE.
  - Any pending result is discarded and must never be written later.
- States:
  - IDLE -> BUSY when Start=1. On that edge: latch A, B and MDUOp; load counter with MULT_CYCLES (MDUOp[1]=0) or DIV_CYCLES (MDUOp[1]=1).
  - BUSY: counter decrements each edge. When counter==1, the next edge writes results to HI/LO and returns to IDLE.
- Timing:
  - If Start is sampled in cycle k, Busy=1 in cycles k+1 .. k+N.
  - HI/LO show the new values from cycle k+N+1, which is the same cycle Busy returns to 0.
  - Back-to-back issue is therefore possible in cycle k+N+1.
- Arithmetic (on the latched operands):
  - multu: {HI,LO} = 64-bit unsigned A*B.
  - mult: {HI,LO} = 64-bit two's-complement A*B.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: signed division truncating toward zero; LO = quotient, HI = remainder carrying the dividend's sign. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - B==0 (div or divu): full busy period still runs; HI/LO unchanged at completion.
- Direct writes:
  - In IDLE, HIWrite=1 sets HI <= A and LOWrite=1 sets LO <= A on the next edge. Both may be set together.
  - Start takes priority over HIWrite/LOWrite in the same cycle.
  - While BUSY: Start, HIWrite and LOWrite are ignored. The Stall logic guarantees they do not occur.
- Stall:
  - Combinational: Stall = MD && (Start || Busy).
  - Covers the issue cycle, so an MD instruction in D never enters E while the unit is starting or busy.
  - Stall=0 whenever MD=0.
- Reads: mfhi/mflo read the registered HI/LO. No internal bypass of in-flight results.

Test Plan:
- multu, A=0xFFFFFFFF, B=2, Start for 1 cycle -> Busy=1 for exactly 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE with Busy=0 in the same cycle.
- mult, A=0xFFFFFFFD (-3), B=7 -> after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div and divu, 10 busy cycles each:
  - div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then divu A=7, B=2 -> LO=3, HI=1.
  - Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo, then divu A=5, B=0 -> Busy for 10 cycles, then HI=0x11, LO=0x22.
- Stall and direct-write checks:
  - Hold MD=1 from the Start cycle onward -> Stall=1 in the Start cycle and all 5 busy cycles, then 0.
  - HIWrite with A=0xABCD in a busy cycle -> HI unaffected.
  - The same HIWrite in IDLE -> HI=0xABCD the next cycle.
- Start mult 3*4, assert reset in the 3rd busy cycle -> next cycle Busy=0, HI=LO=0. Run 10 more idle cycles: HI/LO stay 0, with no late result write.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the E stage: fixed-latency busy sequence, owns HI/LO,
// and raises the D-stage stall for MD-class instructions.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        MD,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_u, prod_s, result;
  logic [31:0] den_u, quot_u, rem_u;
  logic [31:0] abs_a, abs_b, den_s, mag_q, mag_r, quot_s, rem_s;

  // Result datapath works only on the operands latched at issue time.
  always_comb begin
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    quot_u = a_q / den_u;
    rem_u  = a_q % den_u;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    den_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    mag_q  = abs_a / den_s;
    mag_r  = abs_a % den_s;
    quot_s = (a_q[31] ^ b_q[31]) ? (32'd0 - mag_q) : mag_q;
    rem_s  = a_q[31] ? (32'd0 - mag_r) : mag_r;

    case (op_q)
      2'b00:   result = prod_u;
      2'b01:   result = prod_s;
      2'b10:   result = {rem_u, quot_u};
      default: result = {rem_s, quot_s};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = BUSY;
          a_d     = A;
          b_d     = B;
          op_d    = MDUOp;
          count_d = MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else begin
          if (HIWrite) hi_d = A;
          if (LOWrite) lo_d = A;
        end
      end
      BUSY: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          count_d = '0;
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          if (!(op_q[1] && (b_q == 32'd0))) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy  = (state_q == BUSY);
  assign Stall = MD && (Start || Busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: issued ops push expected HI/LO and latency,
// a monitor pops and compares whenever Busy drops.
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        MD;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .MD(MD),
    .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  bit          expect_abort = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: whole-word arithmetic on 64-bit integers.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint unsigned ua, ub;
    longint          sa, sb, q, r;
    logic [63:0]     res;
    ua = 64'(a);
    ub = 64'(b);
    sa = $signed(a);
    sb = $signed(b);
    res = {hi, lo};
    case (op)
      2'b00: res = ua * ub;
      2'b01: res = sa * sb;
      2'b10: if (b != 0) res = {a % b, a / b};
      default: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
    endcase
    return res;
  endfunction

  // Called at a negedge: drives a one-cycle Start and records the expected outcome.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    r = refResult(op, a, b, model_hi, model_lo);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.cycles = op[1] ? DIV_N : MULT_N;
    exp_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    Start = 1'b1;
    MDUOp = op;
    A = a;
    B = b;
  endtask

  task automatic endIssue();
    @(negedge clk);
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (Busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle still busy after %0d cycles", budget);
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b);
    endIssue();
    waitIdle(40);
  endtask

  task automatic directWrite(input logic hw, input logic lw, input logic [31:0] val);
    HIWrite = hw;
    LOWrite = lw;
    A = val;
    if (hw) model_hi = val;
    if (lw) model_lo = val;
    @(negedge clk);
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    checkOutput("direct_hi", HI, model_hi);
    checkOutput("direct_lo", LO, model_lo);
  endtask

  // Monitor: on every falling Busy, compare against the oldest expectation.
  initial begin
    bit   prev_busy = 0;
    int   busy_len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        busy_len++;
      end else if (prev_busy) begin
        if (expect_abort) begin
          expect_abort = 0;
          checkOutput("abort_hi", HI, 32'h0);
          checkOutput("abort_lo", LO, 32'h0);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=completion expected=none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("busy_len", busy_len, e.cycles);
          checkOutput("result_hi", HI, e.hi);
          checkOutput("result_lo", LO, e.lo);
        end
        busy_len = 0;
      end
      prev_busy = (Busy === 1'b1);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog timeout reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] hi_before;
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1;
    Start = 1'b0;
    MDUOp = 2'b00;
    A = '0;
    B = '0;
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    MD = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_hi", HI, 0);
    checkOutput("reset_lo", LO, 0);
    checkOutput("reset_stall", Stall, 0);

    $display("[TB] directed arithmetic");
    runOp(2'b00, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu_hi", HI, 32'h0000_0001);
    checkOutput("multu_lo", LO, 32'hFFFF_FFFE);
    runOp(2'b01, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
    checkOutput("mult_lo", LO, 32'hFFFF_FFEB);
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_lo", LO, 32'hFFFF_FFFD);
    checkOutput("div_hi", HI, 32'hFFFF_FFFF);
    runOp(2'b10, 32'd7, 32'd2);
    checkOutput("divu_lo", LO, 32'd3);
    checkOutput("divu_hi", HI, 32'd1);
    runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_ovf_lo", LO, 32'h8000_0000);
    checkOutput("div_ovf_hi", HI, 32'h0);

    $display("[TB] divide by zero keeps HI/LO");
    directWrite(1'b1, 1'b0, 32'h11);
    directWrite(1'b0, 1'b1, 32'h22);
    runOp(2'b10, 32'd5, 32'd0);
    checkOutput("div0_hi", HI, 32'h11);
    checkOutput("div0_lo", LO, 32'h22);

    $display("[TB] stall window");
    MD = 1'b1;
    #1 checkOutput("stall_md_idle", Stall, 0);
    applyStimulus(2'b00, 32'd9, 32'd9);
    #1 checkOutput("stall_issue", Stall, 1);
    endIssue();
    for (int i = 0; i < MULT_N; i++) begin
      if (i > 0) @(negedge clk);
      #1 checkOutput("stall_busy", Stall, 1);
    end
    @(negedge clk);
    #1 checkOutput("stall_after", Stall, 0);
    checkOutput("busy_after", Busy, 0);
    MD = 1'b0;

    $display("[TB] writes while busy are ignored");
    hi_before = model_hi;
    applyStimulus(2'b00, 32'd6, 32'd7);
    endIssue();
    HIWrite = 1'b1;
    A = 32'hABCD;
    @(negedge clk);
    HIWrite = 1'b0;
    checkOutput("busy_write_hi", HI, hi_before);
    waitIdle(40);
    checkOutput("busy_write_result", HI, 32'h0);
    directWrite(1'b1, 1'b0, 32'hABCD);
    checkOutput("idle_write_hi", HI, 32'hABCD);

    $display("[TB] randomized ops");
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) directWrite(1'($urandom), 1'($urandom), $urandom);
      MD = 1'($urandom);
      applyStimulus(op, ra, rb);
      #1 checkOutput("rand_stall", Stall, {31'b0, MD});
      MD = 1'b0;
      endIssue();
      waitIdle(40);
    end

    $display("[TB] reset mid-operation");
    Start = 1'b1;
    MDUOp = 2'b01;
    A = 32'd3;
    B = 32'd4;
    expect_abort = 1;
    endIssue();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    checkOutput("abort_busy", Busy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_hi", HI, 32'h0);
      checkOutput("idle_lo", LO, 32'h0);
      checkOutput("idle_busy", Busy, 0);
    end
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("abort_seen", {31'b0, expect_abort}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
